router_fsm: RTL and testbench

//  Control FSM of the 1x3 packet router; sits upstream of the three output FIFOs.

---
 rtl/router_fsm_if.sv | 38 +++
 rtl/router_fsm.sv | 125 ++++++++++++
 tb/tb_router_fsm.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/router_fsm_if.sv
// Source/FIFO-side handshake bundle of the 1x3 router control FSM.
// slave = FSM side, master = source/register-stage/FIFO side.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_rst_0;
    logic       soft_rst_1;
    logic       soft_rst_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
    logic       drop_pkt;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_rst_0, soft_rst_1, soft_rst_2, parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               write_enb_reg, rst_int_reg, busy, drop_pkt
    );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: address decode, header/payload/parity sequencing.
// ROUTER_FSM_WAIT_TIMEOUT_EN adds a WAIT_TILL_EMPTY timeout that drops the packet.
module router_fsm #(
    parameter int WAIT_LIMIT = 30
) (
    input  logic         clk,
    input  logic         rst,
    router_fsm_if.slave  bus
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       empty_in, empty_sel, soft_sel, drop;

    // Empty flag of the FIFO named by the incoming header vs. the latched address.
    always_comb begin
        empty_in = 1'b0;
        case (bus.data_in)
            2'd0:    empty_in = bus.fifo_empty_0;
            2'd1:    empty_in = bus.fifo_empty_1;
            2'd2:    empty_in = bus.fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
    end

    always_comb begin
        empty_sel = 1'b0;
        soft_sel  = 1'b0;
        case (addr_q)
            2'd0:    begin empty_sel = bus.fifo_empty_0; soft_sel = bus.soft_rst_0; end
            2'd1:    begin empty_sel = bus.fifo_empty_1; soft_sel = bus.soft_rst_1; end
            2'd2:    begin empty_sel = bus.fifo_empty_2; soft_sel = bus.soft_rst_2; end
            default: begin empty_sel = 1'b0;             soft_sel = 1'b0;           end
        endcase
    end

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    localparam logic [4:0] WAIT_LAST = 5'(WAIT_LIMIT - 1);
    logic [4:0] wait_cnt_q, wait_cnt_d;
    logic       timeout;

    // Only DECODE_ADDRESS enters WAIT_TILL_EMPTY, so the count is zero on entry.
    assign wait_cnt_d = (state_q == WAIT_TILL_EMPTY) ? wait_cnt_q + 5'd1 : 5'd0;
    assign timeout    = (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= 5'd0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`else
    logic timeout;
    logic unused_wait_limit;
    assign timeout           = 1'b0;
    assign unused_wait_limit = ^WAIT_LIMIT;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drop    = 1'b0;
        case (state_q)
            DECODE_ADDRESS:
                if (bus.pkt_valid && bus.data_in != 2'd3) begin
                    addr_d  = bus.data_in;
                    state_d = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA:
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
                if (empty_sel) state_d = LOAD_FIRST_DATA;
                else if (timeout) begin
                    state_d = DECODE_ADDRESS;
                    drop    = 1'b1;
                end
            default: state_d = DECODE_ADDRESS;
        endcase
        // Read-side timeout of the addressed FIFO abandons the packet in flight.
        if (state_q != DECODE_ADDRESS && soft_sel) begin
            state_d = DECODE_ADDRESS;
            drop    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                               (state_q == LOAD_PARITY);
    assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
    assign bus.drop_pkt      = drop;
endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: stimulus pushes expected strobes, a negedge monitor checks them.
module tb_router_fsm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_fsm_if bus ();
  router_fsm #(.WAIT_LIMIT(30)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum {DEC, LFD, LD, FULL, LAF, LP, CPE, WT, WTD} exp_t;
  typedef struct {
    logic [8:0] v;
    string      name;
  } chk_t;

  chk_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   step_n   = 0;

  // {detect_add, lfd, ld, laf, full, we, rst_int, busy, drop_pkt}
  function automatic logic [8:0] outs(input exp_t s);
    case (s)
      DEC:     return 9'b100000000;
      LFD:     return 9'b010000010;
      LD:      return 9'b001001000;
      LAF:     return 9'b000101010;
      FULL:    return 9'b000010010;
      LP:      return 9'b000001010;
      CPE:     return 9'b000000110;
      WT:      return 9'b000000010;
      WTD:     return 9'b000000011;
      default: return 9'b000000000;
    endcase
  endfunction

  task automatic tick(input exp_t s);
    chk_t c;
    @(posedge clk);
    #1;
    step_n++;
    c.v    = outs(s);
    c.name = $sformatf("%s@%0d", s.name(), step_n);
    exp_q.push_back(c);
  endtask

  wire [8:0] act = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                    bus.write_enb_reg, bus.rst_int_reg, bus.busy, bus.drop_pkt};

  task automatic chk(input logic ok, input string name);
    n_assert++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: strobes %b", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      chk_t c;
      c = exp_q.pop_front();
      n_assert++;
      if (act !== c.v) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", c.name, act, c.v);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.pkt_valid = 1'b0; bus.data_in = 2'd0; bus.fifo_full = 1'b0;
    bus.fifo_empty_0 = 1'b1; bus.fifo_empty_1 = 1'b1; bus.fifo_empty_2 = 1'b1;
    bus.soft_rst_0 = 1'b0; bus.soft_rst_1 = 1'b0; bus.soft_rst_2 = 1'b0;
    bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0;

    // reset
    tick(DEC); tick(DEC);
    chk(act === 9'b100000000, "reset_state");
    rst = 1'b0;

    // packet to FIFO 1 with 6 payload bytes
    bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
    tick(LFD);
    repeat (6) tick(LD);
    bus.pkt_valid = 1'b0;
    tick(LP); tick(CPE); tick(DEC); tick(DEC);

    // FIFO full mid-packet, then low_pkt_valid and parity-check-full path
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
    tick(LFD); tick(LD); tick(LD); tick(LD);
    bus.fifo_full = 1'b1;
    repeat (4) tick(FULL);
    bus.fifo_full = 1'b0;
    tick(LAF);
    bus.low_pkt_valid = 1'b1;
    tick(LP);
    bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0; bus.fifo_full = 1'b1;
    tick(CPE); tick(FULL);
    bus.fifo_full = 1'b0; bus.parity_done = 1'b1;
    tick(LAF); tick(DEC);
    bus.parity_done = 1'b0;

    // busy destination FIFO 2, then invalid address 3
    bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b0;
    repeat (10) tick(WT);
    bus.fifo_empty_2 = 1'b1;
    tick(LFD); tick(LD);
    bus.pkt_valid = 1'b0;
    tick(LP); tick(CPE); tick(DEC);
    bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
    tick(DEC); tick(DEC);
    bus.pkt_valid = 1'b0;
    tick(DEC);

    // soft reset: non-addressed ignored, addressed returns to decode
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
    tick(LFD); tick(LD);
    bus.soft_rst_1 = 1'b1;
    tick(LD);
    bus.soft_rst_1 = 1'b0; bus.soft_rst_0 = 1'b1; bus.pkt_valid = 1'b0;
    tick(DEC);
    tick(DEC);
    bus.soft_rst_0 = 1'b0;

    // wait on FIFO 0 that never drains
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0; bus.fifo_empty_0 = 1'b0;
    tick(WT);
    bus.pkt_valid = 1'b0;
`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
    repeat (28) tick(WT);
    tick(WTD);
    chk(bus.drop_pkt === 1'b1 && bus.busy === 1'b1, "wait_expired_drop");
    tick(DEC);
    chk(bus.detect_add === 1'b1 && bus.drop_pkt === 1'b0, "wait_expired_decode");
    tick(DEC);
`else
    repeat (100) tick(WT);
    chk(bus.busy === 1'b1 && bus.detect_add === 1'b0 && bus.drop_pkt === 1'b0,
        "wait_no_expiry");
    bus.soft_rst_0 = 1'b1;
    tick(DEC);
    bus.soft_rst_0 = 1'b0;
`endif
    bus.fifo_empty_0 = 1'b1;

    // reset in mid-packet wins
    bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
    tick(LFD);
    rst = 1'b1;
    tick(DEC);
    rst = 1'b0; bus.pkt_valid = 1'b0;
    tick(DEC);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
